mcs_io_initiator: RTL and testbench
===================================

// Module: mcs_io_initiator
// PURPOSE
//  Bus-master end of the MicroBlaze MCS IO bus: the same protocol a CPU drives into chu_mcs_bridge.
//  Accepts read/write commands on a valid/ready port, issues one IO-bus transaction per command,
//  waits for io_ready and returns a response with data or a timeout error.
//  Replaces the CPU for bring-up and host-driven (UART debug) access to the fpro MMIO space.
// PARAMETERS
//  TIMEOUT_CYCLES  255  WAIT-state cycles with no io_ready before the transaction is abandoned (>=1)
//  TO_W            8    timeout counter width; must hold TIMEOUT_CYCLES
// PORTS
//  clk              in   1   system clock, 100 MHz
//  reset_n          in   1   synchronous, active-low reset
//  cmd_valid        in   1   command present
//  cmd_ready        out  1   command accepted when cmd_valid & cmd_ready
//  cmd_wr           in   1   1=write, 0=read
//  cmd_addr         in   32  byte address (BRG_BASE region for MMIO)
//  cmd_be           in   4   byte enables
//  cmd_wdata        in   32  write data
//  rsp_valid        out  1   response present
//  rsp_ready        in   1   response consumed when rsp_valid & rsp_ready
//  rsp_rdata        out  32  read data (0 for writes and on timeout)
//  rsp_err          out  1   1 = timeout
//  io_addr_strobe   out  1   one-cycle transaction strobe
//  io_read_strobe   out  1   one-cycle, coincident with addr strobe, reads only
//  io_write_strobe  out  1   one-cycle, coincident with addr strobe, writes only
//  io_address       out  32  held from STROBE until response accepted
//  io_byte_enable   out  4   held as io_address
//  io_write_data    out  32  held as io_address
//  io_read_data     in   32  sampled in the io_ready cycle
//  io_ready         in   1   responder completion, may be asserted in the strobe cycle
//  busy             out  1   state != IDLE
// BEHAVIOUR
//  - All outputs are registered. Reset (reset_n=0 at a clk edge) forces:
//    state=IDLE, cmd_ready=1, strobes=0, rsp_valid=0, rsp_err=0, rsp_rdata=0,
//    io_address/io_byte_enable/io_write_data=0, busy=0.
//    Reset mid-transaction abandons it with no response.
//  - FSM states: IDLE, STROBE, WAIT, RESP.
//  - IDLE: cmd_ready=1. On accept, latch addr/be/wdata/wr and go to STROBE.
//  - STROBE (exactly 1 cycle): io_addr_strobe=1 plus io_read_strobe or io_write_strobe, cmd_ready=0.
//    If io_ready=1 in this cycle, capture the response and go to RESP; otherwise go to WAIT with the counter cleared.
//  - WAIT: strobes low; counter increments each cycle.
//    - io_ready=1: capture rdata (reads), err=0, go to RESP.
//    - counter == TIMEOUT_CYCLES-1 with no io_ready: err=1, rdata=0, go to RESP.
//    - If io_ready coincides with the last count, io_ready wins.
//  - RESP: rsp_valid=1 and stays high, payload stable, until rsp_ready. Then go to IDLE with cmd_ready=1 the next cycle.
//  - io_ready is ignored in IDLE and RESP; a late ready after a timeout is dropped.
//  - Strict one outstanding transaction, no pipelining.
//    - Minimum cmd-accept to rsp_valid: 2 cycles (zero-wait responder).
//    - Minimum issue interval: 3 cycles with rsp_ready held at 1.
//  - Write responses carry rsp_rdata=0.
//  - io_read_data is never forwarded combinationally.
// STRUCTURE
//  - Package io_bus_pkg holds:
//    - typedef enum logic [1:0] {IDLE, STROBE, WAIT, RESP} io_state_t
//    - typedef struct {wr, addr, be, wdata} io_cmd_t
//    - localparam RDATA_ON_ERR = 32'h0
//  - Single module; the timeout counter is inline.
//  - No sub-module is needed (roughly 150 lines of RTL).
// TESTING
//  1. Zero-wait read: responder ties io_ready=1, rdata=32'h1234_5678; read 32'hC000_0010
//     -> one-cycle strobes, rsp_valid two cycles after accept, rdata=32'h1234_5678, err=0.
//  2. Wait-state write: be=4'b0011, wdata=32'hA5A5_0F0F, io_ready after 5 cycles
//     -> io_write_strobe high exactly one cycle, address/data held throughout, rsp err=0, rdata=0.
//  3. Timeout: read with io_ready never asserted, TIMEOUT_CYCLES=16
//     -> rsp_valid with err=1, rdata=0; a late io_ready 3 cycles later causes no second response.
//  4. Back-pressure: rsp_ready=0 for 10 cycles -> rsp_valid and payload stable,
//     cmd_ready=0, a pending cmd_valid is not accepted until the response is taken.
//  5. Reset mid-WAIT: reset_n=0 for 1 cycle -> all outputs at reset values next cycle, no response,
//     next command issues normally.
//  6. Back-to-back: 4 reads with cmd_valid and rsp_ready held at 1, zero-wait responder
//     -> 4 strobes spaced exactly 3 cycles apart, responses in order.

Source files
------------

// File: rtl/io_bus_pkg.sv
`default_nettype none
// =============================================================================
// Module      : io_bus_pkg
// Description : Shared types and constants for the MCS IO-bus initiator.
// Revision    : 1.0 - initial release
// =============================================================================
package io_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } io_state_t;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } io_cmd_t;

    localparam logic [31:0] RDATA_ON_ERR = 32'h0;

endpackage
`default_nettype wire

// File: rtl/mcs_io_initiator.sv
`default_nettype none
// =============================================================================
// Module      : mcs_io_initiator
// Description : Command/response master for the MicroBlaze MCS IO bus, one
//               outstanding transaction with a wait-state timeout.
// Revision    : 1.0 - initial release
// =============================================================================
module mcs_io_initiator
    import io_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_wr,
    input  logic [31:0] cmd_addr,
    input  logic [3:0]  cmd_be,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        io_addr_strobe,
    output logic        io_read_strobe,
    output logic        io_write_strobe,
    output logic [31:0] io_address,
    output logic [3:0]  io_byte_enable,
    output logic [31:0] io_write_data,
    input  logic [31:0] io_read_data,
    input  logic        io_ready,
    output logic        busy
);

    localparam logic [TO_W-1:0] c_to_last = TO_W'(TIMEOUT_CYCLES - 1);

    io_state_t       r_state;
    io_cmd_t         r_cmd;
    logic [TO_W-1:0] r_to_cnt;
    logic            r_cmd_ready;
    logic            r_addr_stb;
    logic            r_rd_stb;
    logic            r_wr_stb;
    logic            r_rsp_valid;
    logic            r_rsp_err;
    logic [31:0]     r_rsp_rdata;
    logic            r_busy;
    logic [31:0]     w_cap_rdata;

    // Writes never return bus data, so the capture path is gated by the latched direction.
    assign w_cap_rdata = r_cmd.wr ? 32'h0 : io_read_data;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_cmd       <= '0;
            r_to_cnt    <= '0;
            r_cmd_ready <= 1'b1;
            r_addr_stb  <= 1'b0;
            r_rd_stb    <= 1'b0;
            r_wr_stb    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_busy      <= 1'b0;
        end else begin
            r_addr_stb <= 1'b0;
            r_rd_stb   <= 1'b0;
            r_wr_stb   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_cmd.wr    <= cmd_wr;
                        r_cmd.addr  <= cmd_addr;
                        r_cmd.be    <= cmd_be;
                        r_cmd.wdata <= cmd_wdata;
                        r_state     <= STROBE;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_addr_stb  <= 1'b1;
                        r_rd_stb    <= ~cmd_wr;
                        r_wr_stb    <= cmd_wr;
                    end
                end
                STROBE: begin
                    if (io_ready) begin
                        r_rsp_rdata <= w_cap_rdata;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_to_cnt <= '0;
                        r_state  <= WAIT;
                    end
                end
                WAIT: begin
                    // A ready arriving on the final count still completes normally.
                    if (io_ready) begin
                        r_rsp_rdata <= w_cap_rdata;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else if (r_to_cnt == c_to_last) begin
                        r_rsp_rdata <= RDATA_ON_ERR;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cmd_ready       = r_cmd_ready;
    assign rsp_valid       = r_rsp_valid;
    assign rsp_rdata       = r_rsp_rdata;
    assign rsp_err         = r_rsp_err;
    assign io_addr_strobe  = r_addr_stb;
    assign io_read_strobe  = r_rd_stb;
    assign io_write_strobe = r_wr_stb;
    assign io_address      = r_cmd.addr;
    assign io_byte_enable  = r_cmd.be;
    assign io_write_data   = r_cmd.wdata;
    assign busy            = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mcs_io_initiator.sv
`default_nettype none
// =============================================================================
// Module      : tb_mcs_io_initiator
// Description : Self-checking bench for mcs_io_initiator against a
//               transaction-level model.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_mcs_io_initiator;

    localparam int          TO     = 16;
    localparam int          BUDGET = 200;
    localparam logic [31:0] KEY    = 32'h5A5A_F00D;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_wr = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]  cmd_be = '0;
    logic        cmd_ready, rsp_valid, rsp_err, busy;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        io_addr_strobe, io_read_strobe, io_write_strobe;
    logic [31:0] io_address, io_write_data;
    logic [3:0]  io_byte_enable;
    logic [31:0] io_read_data = '0;
    logic        io_ready = 1'b0;

    mcs_io_initiator #(.TIMEOUT_CYCLES(TO), .TO_W(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_be(cmd_be), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .io_addr_strobe(io_addr_strobe), .io_read_strobe(io_read_strobe),
        .io_write_strobe(io_write_strobe), .io_address(io_address),
        .io_byte_enable(io_byte_enable), .io_write_data(io_write_data),
        .io_read_data(io_read_data), .io_ready(io_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Responder / sink controls (written by the main sequence at negedge)
    int          io_mode = 0;     // 0 fixed zero-wait, 1 ready after wait_k, 2 never, 3 random, 6 addr-derived zero-wait
    int          wait_k = 0;
    int          rr_mode = 1;     // 0 hold low, 1 hold high, 2 random
    logic [31:0] fix_data = '0;
    logic        late_req = 1'b0;
    int          rcnt = 0;

    always @(negedge clk) begin
        #1;
        if (io_addr_strobe) rcnt = 0;
        else rcnt++;
        case (io_mode)
            0: begin io_ready = 1'b1; io_read_data = fix_data; end
            1: begin io_ready = (rcnt == wait_k); io_read_data = $urandom; end
            2: begin io_ready = 1'b0; io_read_data = $urandom; end
            3: begin io_ready = ($urandom_range(0, 2) == 0); io_read_data = $urandom; end
            default: begin io_ready = 1'b1; io_read_data = io_address ^ KEY; end
        endcase
        io_ready = io_ready | late_req;
        case (rr_mode)
            0: rsp_ready = 1'b0;
            1: rsp_ready = 1'b1;
            default: rsp_ready = ($urandom_range(0, 1) == 1);
        endcase
    end

    // Transaction-level model: a command is either absent, in flight (n cycles
    // since its strobe cycle), or completed and waiting to be consumed.
    bit          m_valid = 0, m_active = 0, m_resp = 0, m_wr = 0, m_err = 0;
    int          m_n = 0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
    logic [3:0]  m_be = '0;

    int          cyc = 0, rsp_cnt = 0, stb_cnt = 0, wr_stb_cnt = 0, rv_cyc = 0;
    int          stb_q[$];
    logic [31:0] rq_data[$];
    logic        rq_err[$];
    logic        dut_rv = 1'b0, dut_err = 1'b0;
    logic [31:0] dut_rd = '0;

    always @(posedge clk) begin
        cyc++;
        if (reset_n && dut_rv && rsp_ready) begin
            rsp_cnt++;
            rq_data.push_back(dut_rd);
            rq_err.push_back(dut_err);
        end
        if (!reset_n) begin
            m_valid = 1; m_active = 0; m_resp = 0; m_wr = 0; m_err = 0;
            m_addr = '0; m_be = '0; m_wdata = '0; m_rdata = '0;
        end else if (m_resp) begin
            if (rsp_ready) m_resp = 0;
        end else if (m_active) begin
            if (io_ready) begin
                m_resp = 1; m_active = 0; m_err = 0;
                m_rdata = m_wr ? 32'h0 : io_read_data;
            end else if (m_n == TO) begin
                m_resp = 1; m_active = 0; m_err = 1; m_rdata = 32'h0;
            end else begin
                m_n++;
            end
        end else if (cmd_valid) begin
            m_active = 1; m_n = 0; m_wr = cmd_wr;
            m_addr = cmd_addr; m_be = cmd_be; m_wdata = cmd_wdata;
        end
        #1;
        if (m_valid) begin
            chk("cmd_ready", 32'(cmd_ready), 32'(!m_active && !m_resp));
            chk("busy", 32'(busy), 32'(m_active || m_resp));
            chk("addr_strobe", 32'(io_addr_strobe), 32'(m_active && m_n == 0));
            chk("read_strobe", 32'(io_read_strobe), 32'(m_active && m_n == 0 && !m_wr));
            chk("write_strobe", 32'(io_write_strobe), 32'(m_active && m_n == 0 && m_wr));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_resp));
            if (m_active || m_resp) begin
                chk("io_address", io_address, m_addr);
                chk("io_byte_enable", 32'(io_byte_enable), 32'(m_be));
                chk("io_write_data", io_write_data, m_wdata);
            end
            if (m_resp) begin
                chk("rsp_rdata", rsp_rdata, m_rdata);
                chk("rsp_err", 32'(rsp_err), 32'(m_err));
            end
        end
        if (io_addr_strobe) begin
            stb_cnt++;
            stb_q.push_back(cyc);
        end
        if (io_write_strobe) wr_stb_cnt++;
        if (rsp_valid && !dut_rv) rv_cyc = cyc;
        dut_rv  = rsp_valid;
        dut_rd  = rsp_rdata;
        dut_err = rsp_err;
    end

    int acc_cyc = 0;

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wd);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_be = be; cmd_wdata = wd;
        while (!cmd_ready && n < BUDGET) begin @(negedge clk); n++; end
        chk("issue_accept", 32'(cmd_ready), 32'd1);
        acc_cyc = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || rsp_valid) && n < BUDGET) begin @(negedge clk); n++; end
        chk("wait_idle", 32'(busy || rsp_valid), 32'd0);
    endtask

    task automatic wait_rv();
        int n = 0;
        while (!rsp_valid && n < BUDGET) begin @(negedge clk); n++; end
        chk("wait_rsp_valid", 32'(rsp_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, s0, w0, n;
        logic [31:0] a6[4];

        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_io_address", io_address, 32'h0);
        chk("rst_strobe", 32'(io_addr_strobe), 32'd0);
        reset_n = 1'b1;

        // Zero-wait read
        io_mode = 0; fix_data = 32'h1234_5678; rr_mode = 1;
        s0 = stb_cnt;
        issue(1'b0, 32'hC000_0010, 4'hF, 32'h0);
        wait_idle();
        chk("t1_strobe_cycle", 32'(stb_q[$] - acc_cyc), 32'd1);
        chk("t1_latency", 32'(rv_cyc - acc_cyc), 32'd2);
        chk("t1_rdata", rq_data[$], 32'h1234_5678);
        chk("t1_err", 32'(rq_err[$]), 32'd0);
        chk("t1_strobes", 32'(stb_cnt - s0), 32'd1);

        // Wait-state write
        io_mode = 1; wait_k = 5;
        w0 = wr_stb_cnt;
        issue(1'b1, 32'hC000_0024, 4'b0011, 32'hA5A5_0F0F);
        wait_idle();
        chk("t2_write_strobes", 32'(wr_stb_cnt - w0), 32'd1);
        chk("t2_latency", 32'(rv_cyc - stb_q[$]), 32'd6);
        chk("t2_rdata", rq_data[$], 32'h0);
        chk("t2_err", 32'(rq_err[$]), 32'd0);

        // Timeout, then late ready in RESP and in IDLE
        io_mode = 2; rr_mode = 0;
        r0 = rsp_cnt; s0 = stb_cnt;
        issue(1'b0, 32'hC000_0040, 4'hF, 32'h0);
        wait_rv();
        chk("t3_timeout_latency", 32'(rv_cyc - stb_q[$]), 32'(TO + 1));
        chk("t3_err", 32'(rsp_err), 32'd1);
        chk("t3_rdata", rsp_rdata, 32'h0);
        repeat (3) @(negedge clk);
        late_req = 1'b1;
        @(negedge clk);
        late_req = 1'b0;
        repeat (2) @(negedge clk);
        rr_mode = 1;
        wait_idle();
        late_req = 1'b1;
        @(negedge clk);
        late_req = 1'b0;
        repeat (10) @(negedge clk);
        chk("t3_responses", 32'(rsp_cnt - r0), 32'd1);
        chk("t3_strobes", 32'(stb_cnt - s0), 32'd1);

        // Back-pressure with a pending command
        io_mode = 0; fix_data = 32'hCAFE_0004; rr_mode = 0;
        r0 = rsp_cnt;
        issue(1'b0, 32'hC000_0050, 4'hF, 32'h0);
        wait_rv();
        s0 = stb_cnt;
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 32'hC000_0054; cmd_be = 4'hC; cmd_wdata = 32'h0BAD_F00D;
        repeat (10) begin
            @(negedge clk);
            chk("t4_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("t4_rsp_rdata", rsp_rdata, 32'hCAFE_0004);
        end
        chk("t4_no_strobe", 32'(stb_cnt - s0), 32'd0);
        rr_mode = 1;
        n = 0;
        while (!cmd_ready && n < BUDGET) begin @(negedge clk); n++; end
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_idle();
        chk("t4_strobes", 32'(stb_cnt - s0), 32'd1);
        chk("t4_responses", 32'(rsp_cnt - r0), 32'd2);

        // Reset in the middle of WAIT
        io_mode = 2; rr_mode = 1;
        r0 = rsp_cnt;
        issue(1'b0, 32'hC000_0060, 4'hF, 32'h0);
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("t5_io_address", io_address, 32'h0);
        repeat (30) @(negedge clk);
        chk("t5_no_response", 32'(rsp_cnt - r0), 32'd0);
        io_mode = 0; fix_data = 32'h5555_AAAA;
        issue(1'b0, 32'hC000_0064, 4'hF, 32'h0);
        wait_idle();
        chk("t5_after_rdata", rq_data[$], 32'h5555_AAAA);

        // Back-to-back reads
        io_mode = 6; rr_mode = 1;
        for (int i = 0; i < 4; i++) a6[i] = 32'hC000_0100 + 32'(i * 4);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_be = 4'hF; cmd_addr = a6[0];
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (!cmd_ready && n < BUDGET) begin @(negedge clk); n++; end
            @(negedge clk);
            if (i < 3) cmd_addr = a6[i + 1];
            else cmd_valid = 1'b0;
        end
        wait_idle();
        n = stb_q.size();
        for (int i = 1; i < 4; i++)
            chk("t6_strobe_gap", 32'(stb_q[n - 4 + i] - stb_q[n - 5 + i]), 32'd3);
        n = rq_data.size();
        for (int i = 0; i < 4; i++)
            chk("t6_rdata_order", rq_data[n - 4 + i], a6[i] ^ KEY);

        // Randomized traffic
        r0 = rsp_cnt;
        rr_mode = 2;
        for (int i = 0; i < 40; i++) begin
            io_mode = ($urandom_range(0, 4) == 0) ? 2 : 3;
            issue(1'($urandom_range(0, 1)), $urandom, 4'($urandom), $urandom);
            wait_idle();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        chk("rand_responses", 32'(rsp_cnt - r0), 32'd40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
